// File: rtl/mem_bus_target_pkg.sv
// Shared constants for the byte-wide memory bus target: FSM encoding, MMIO register
// offsets, CTRL/STATUS bit positions and the compare register reset value.
package mem_bus_target_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHi   = 2'd1,
    StAddr = 2'd2
  } bus_state_e;

  localparam logic [3:0] OffCntLo  = 4'd0;
  localparam logic [3:0] OffCntHi  = 4'd1;
  localparam logic [3:0] OffCmpLo  = 4'd2;
  localparam logic [3:0] OffCmpHi  = 4'd3;
  localparam logic [3:0] OffCtrl   = 4'd4;
  localparam logic [3:0] OffStatus = 4'd5;

  localparam int unsigned CtrlRunBit   = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned StatPendBit  = 0;
  localparam int unsigned StatErrBit   = 1;

  localparam logic [15:0] CmpResetVal = 16'hFFFF;

endpackage

// File: rtl/mem_bus_timer.sv
// Free-running compare timer behind the MMIO window: counter, compare, CTRL, pending flag,
// CNT_HI shadow and the register read mux (err is owned by the bus FSM and passed in).
module mem_bus_timer
  import mem_bus_target_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       wr_en_i,
  input  logic [3:0] wr_off_i,
  input  logic [7:0] wr_data_i,
  input  logic       snap_i,
  input  logic       err_i,
  input  logic [3:0] rd_off_i,
  output logic [7:0] rd_data_o,
  output logic       irq_o
);

  logic [15:0] count_q, count_d;
  logic [15:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        cnt_clr;
  logic        match;

  always_comb begin
    cnt_clr  = wr_en_i && ((wr_off_i == OffCntLo) || (wr_off_i == OffCntHi));
    match    = ctrl_q[CtrlRunBit] && (count_q == cmp_q);
    count_d  = count_q;
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;

    if (cnt_clr || match) begin
      count_d = '0;
    end else if (ctrl_q[CtrlRunBit]) begin
      count_d = count_q + 16'd1;
    end

    if (wr_en_i) begin
      case (wr_off_i)
        OffCmpLo:  cmp_d[7:0]  = wr_data_i;
        OffCmpHi:  cmp_d[15:8] = wr_data_i;
        OffCtrl:   ctrl_d      = wr_data_i[1:0];
        OffStatus: if (wr_data_i[StatPendBit]) pend_d = 1'b0;
        default: ;
      endcase
    end

    // A match in the same cycle as a W1C keeps the flag set; a counter clear suppresses the match.
    if (match && !cnt_clr) pend_d = 1'b1;
    if (snap_i) shadow_d = count_q[15:8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      cmp_q    <= CmpResetVal;
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
    end else if (en_i) begin
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (rd_off_i)
      OffCntLo:  rd_data_o = count_q[7:0];
      OffCntHi:  rd_data_o = shadow_q;
      OffCmpLo:  rd_data_o = cmp_q[7:0];
      OffCmpHi:  rd_data_o = cmp_q[15:8];
      OffCtrl:   rd_data_o[1:0] = ctrl_q;
      OffStatus: begin
        rd_data_o[StatPendBit] = pend_q;
        rd_data_o[StatErrBit]  = err_i;
      end
      default: ;
    endcase
  end

  assign irq_o = pend_q & ctrl_q[CtrlIrqEnBit];

endmodule

// File: rtl/mem_bus_target.sv
// Byte-wide multiplexed address/data bus target: address-phase FSM, RAM array and a
// 16-byte MMIO window (MMIO_BASE assumed 16-byte aligned) served by mem_bus_timer.
module mem_bus_target
  import mem_bus_target_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 256,
  parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       ena,
  input  logic [7:0] bus_in,
  input  logic       latch_hi,
  input  logic       latch_lo,
  input  logic       write,
  input  logic       ind,
  output logic [7:0] data_out,
  output logic       interrupt
);

  localparam int unsigned AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;

  bus_state_e  state_q;
  logic [7:0]  hi_q;
  logic [6:0]  lo_q;
  logic        err_q;
  logic [7:0]  mem_q [RAM_BYTES];

  logic        lo_acc, wr_acc, err_set, snap, err_clr;
  logic [15:0] wr_addr, rd_addr;
  logic        wr_ram, wr_mmio, rd_ram, rd_mmio, rd_valid;
  logic [7:0]  tmr_rd;

  // latch_hi wins outright; latch_lo and write are only honoured in their proper phase.
  always_comb begin
    lo_acc  = 1'b0;
    wr_acc  = 1'b0;
    err_set = 1'b0;
    if (!latch_hi) begin
      if (latch_lo) begin
        if (state_q == StHi) lo_acc = 1'b1;
        else                 err_set = 1'b1;
      end else if (write) begin
        if (state_q == StAddr) wr_acc = 1'b1;
        else                   err_set = 1'b1;
      end
    end
  end

  assign wr_addr = {hi_q, lo_q, ind};
  assign wr_ram  = wr_acc && ((wr_addr >> AW) == 16'd0);
  assign wr_mmio = wr_acc && !wr_ram && (wr_addr[15:4] == MMIO_BASE[15:4]);
  assign err_clr = wr_mmio && (wr_addr[3:0] == OffStatus) && bus_in[StatErrBit];
  assign snap    = lo_acc && ({hi_q, bus_in[7:1]} == MMIO_BASE[15:1]);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else if (ena) begin
      if (latch_hi) begin
        hi_q    <= bus_in;
        state_q <= StHi;
      end else if (lo_acc) begin
        lo_q    <= bus_in[7:1];
        state_q <= StAddr;
      end
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // RAM contents survive reset by design.
  always_ff @(posedge clk) begin
    if (!reset_in && ena && wr_ram) mem_q[wr_addr[AW-1:0]] <= bus_in;
  end

  // Zero-latency read: during the latch_lo cycle the low address comes straight off the bus.
  assign rd_addr  = {hi_q, (latch_lo ? bus_in[7:1] : lo_q), ind};
  assign rd_valid = ((state_q == StHi) && latch_lo) || (state_q == StAddr);
  assign rd_ram   = ((rd_addr >> AW) == 16'd0);
  assign rd_mmio  = !rd_ram && (rd_addr[15:4] == MMIO_BASE[15:4]);

  always_comb begin
    data_out = 8'hFF;
    if (rd_valid) begin
      if (rd_ram)       data_out = mem_q[rd_addr[AW-1:0]];
      else if (rd_mmio) data_out = tmr_rd;
    end
  end

  mem_bus_timer u_timer (
    .clk_i     (clk),
    .rst_i     (reset_in),
    .en_i      (ena),
    .wr_en_i   (wr_mmio),
    .wr_off_i  (wr_addr[3:0]),
    .wr_data_i (bus_in),
    .snap_i    (snap),
    .err_i     (err_q),
    .rd_off_i  (rd_addr[3:0]),
    .rd_data_o (tmr_rd),
    .irq_o     (interrupt)
  );

endmodule
